// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with operand forwarding and load-use detection.
// Feeds ALU operands from EX/MEM, MEM/WB or latched register data.
module id_ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5,
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alu_src,
    input  logic [OP_W-1:0] id_alu_op,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            exm_reg_write,
    input  logic [RA_W-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_reg_write,
    input  logic [RA_W-1:0] mwb_rd,
    input  logic [XLEN-1:0] mwb_result,
    output logic [XLEN-1:0] alu_in_1,
    output logic [XLEN-1:0] alu_in_2,
    output logic [OP_W-1:0] alu_op,
    output logic            ex_valid,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic [XLEN-1:0] ex_store_data,
    output logic            hazard_stall
);
    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            alu_src;
        logic [OP_W-1:0] alu_op;
        logic            reg_write;
        logic            mem_read;
    } ex_t;

    localparam ex_t EX_BUBBLE = '{
        valid: 1'b0, rs1: {RA_W{1'b0}}, rs2: {RA_W{1'b0}}, rd: {RA_W{1'b0}},
        rs1_data: {XLEN{1'b0}}, rs2_data: {XLEN{1'b0}}, imm: {XLEN{1'b0}},
        alu_src: 1'b0, alu_op: {OP_W{1'b1}}, reg_write: 1'b0, mem_read: 1'b0
    };

    ex_t ex_q, ex_d, id_ex;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;

    always_comb begin
        id_ex = '{
            valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
            rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
            alu_src: id_alu_src, alu_op: id_alu_op,
            reg_write: id_reg_write & id_valid, mem_read: id_mem_read & id_valid
        };
    end

    // rs2 of a store (imm operand, no writeback) still needs the loaded value
    assign hazard_stall = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                          ((id_rs1 == ex_q.rd) |
                           ((id_rs2 == ex_q.rd) & (!id_alu_src | !id_reg_write)));

    assign ex_d = flush ? EX_BUBBLE : stall ? ex_q : hazard_stall ? EX_BUBBLE : id_ex;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ex_q <= EX_BUBBLE;
        else          ex_q <= ex_d;
    end

    assign rs1_fwd = (ex_q.rs1 != '0 && exm_reg_write && exm_rd == ex_q.rs1) ? exm_result :
                     (ex_q.rs1 != '0 && mwb_reg_write && mwb_rd == ex_q.rs1) ? mwb_result :
                     ex_q.rs1_data;
    assign rs2_fwd = (ex_q.rs2 != '0 && exm_reg_write && exm_rd == ex_q.rs2) ? exm_result :
                     (ex_q.rs2 != '0 && mwb_reg_write && mwb_rd == ex_q.rs2) ? mwb_result :
                     ex_q.rs2_data;

    assign alu_in_1      = rs1_fwd;
    assign alu_in_2      = ex_q.alu_src ? ex_q.imm : rs2_fwd;
    assign ex_store_data = rs2_fwd;
    assign alu_op        = ex_q.alu_op;
    assign ex_valid      = ex_q.valid;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed scenarios plus randomized run against a pipeline-level model.
module tb_id_ex_operand_stage;
    logic        clk = 1'b0;
    logic        reset_n, stall, flush, id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_alu_src;
    logic [3:0]  id_alu_op;
    logic        id_reg_write, id_mem_read;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_result;
    logic [31:0] alu_in_1, alu_in_2, ex_store_data;
    logic [3:0]  alu_op;
    logic        ex_valid, ex_reg_write, ex_mem_read, hazard_stall;
    logic [4:0]  ex_rd;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_op(alu_op),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_store_data(ex_store_data),
        .hazard_stall(hazard_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic src, input logic [3:0] op,
                          input logic rw, input logic mr);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_alu_src = src; id_alu_op = op; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic clear_fwd();
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clear_fwd();
        stall = 0; flush = 0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 0; stall = 0; flush = 0;
        set_id(1, 3, 4, 5, 32'h1, 32'h2, 32'h3, 1, 4'h2, 1, 1);
        clear_fwd();
        repeat (2) tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid got=%0b want=0", ex_valid); else passed++;
        total++; if (alu_op !== 4'hF) $display("FAIL reset_alu_op got=%h want=f", alu_op); else passed++;
        total++; if (alu_in_1 !== 32'h0) $display("FAIL reset_alu_in_1 got=%h want=0", alu_in_1); else passed++;
        total++; if (alu_in_2 !== 32'h0) $display("FAIL reset_alu_in_2 got=%h want=0", alu_in_2); else passed++;
        total++; if (hazard_stall !== 1'b0) $display("FAIL reset_hazard got=%0b want=0", hazard_stall); else passed++;
        reset_n = 1;
        idle();
    endtask

    task automatic test_reset_midstream();
        set_id(1, 1, 2, 3, 32'h11, 32'h22, 32'h0, 0, 4'h2, 1, 0);
        tick();
        total++; if (ex_valid !== 1'b1) $display("FAIL mid_pre_valid got=%0b want=1", ex_valid); else passed++;
        exm_reg_write = 1; exm_rd = 1; exm_result = 32'h77;
        #2 reset_n = 0;
        #1;
        total++; if (ex_valid !== 1'b0) $display("FAIL mid_async_valid got=%0b want=0", ex_valid); else passed++;
        tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL mid_ex_valid got=%0b want=0", ex_valid); else passed++;
        total++; if (alu_op !== 4'hF) $display("FAIL mid_alu_op got=%h want=f", alu_op); else passed++;
        total++; if (alu_in_1 !== 32'h0) $display("FAIL mid_alu_in_1 got=%h want=0", alu_in_1); else passed++;
        total++; if (alu_in_2 !== 32'h0) $display("FAIL mid_alu_in_2 got=%h want=0", alu_in_2); else passed++;
        total++; if (ex_reg_write !== 1'b0) $display("FAIL mid_reg_write got=%0b want=0", ex_reg_write); else passed++;
        reset_n = 1;
        idle();
    endtask

    task automatic test_forward();
        set_id(1, 5, 7, 3, 32'h1, 32'h2, 32'h0, 0, 4'h0, 1, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exm_reg_write = 1; exm_rd = 5; exm_result = 100;
        mwb_reg_write = 1; mwb_rd = 7; mwb_result = 200;
        #1;
        total++; if (alu_in_1 !== 32'd100) $display("FAIL fwd_in1 got=%0d want=100", alu_in_1); else passed++;
        total++; if (alu_in_2 !== 32'd200) $display("FAIL fwd_in2 got=%0d want=200", alu_in_2); else passed++;
        total++; if (ex_store_data !== 32'd200) $display("FAIL fwd_store got=%0d want=200", ex_store_data); else passed++;
        total++; if (ex_rd !== 5'd3) $display("FAIL fwd_rd got=%0d want=3", ex_rd); else passed++;
        total++; if (ex_reg_write !== 1'b1) $display("FAIL fwd_rw got=%0b want=1", ex_reg_write); else passed++;
        idle();
    endtask

    task automatic test_priority();
        set_id(1, 4, 0, 2, 32'd99, 32'h0, 32'h0, 0, 4'h1, 1, 0);
        tick();
        exm_reg_write = 1; exm_rd = 4; exm_result = 11;
        mwb_reg_write = 1; mwb_rd = 4; mwb_result = 22;
        #1;
        total++; if (alu_in_1 !== 32'd11) $display("FAIL prio_exm got=%0d want=11", alu_in_1); else passed++;
        exm_reg_write = 0;
        #1;
        total++; if (alu_in_1 !== 32'd22) $display("FAIL prio_mwb got=%0d want=22", alu_in_1); else passed++;
        mwb_reg_write = 0;
        #1;
        total++; if (alu_in_1 !== 32'd99) $display("FAIL prio_latched got=%0d want=99", alu_in_1); else passed++;
        set_id(1, 0, 0, 2, 32'h0, 32'h0, 32'h0, 0, 4'h1, 1, 0);
        clear_fwd();
        tick();
        exm_reg_write = 1; exm_rd = 0; exm_result = 11;
        mwb_reg_write = 1; mwb_rd = 0; mwb_result = 22;
        #1;
        total++; if (alu_in_1 !== 32'd0) $display("FAIL prio_x0 got=%0d want=0", alu_in_1); else passed++;
        idle();
    endtask

    task automatic test_load_use();
        set_id(1, 0, 0, 6, 32'h0, 32'h0, 32'h8, 1, 4'h0, 1, 1);
        tick();
        set_id(1, 6, 1, 3, 32'hDEAD, 32'h1, 32'h0, 0, 4'h1, 1, 0);
        #1;
        total++; if (hazard_stall !== 1'b1) $display("FAIL lu_detect got=%0b want=1", hazard_stall); else passed++;
        tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble_valid got=%0b want=0", ex_valid); else passed++;
        total++; if (alu_op !== 4'hF) $display("FAIL lu_bubble_op got=%h want=f", alu_op); else passed++;
        total++; if (hazard_stall !== 1'b0) $display("FAIL lu_one_cycle got=%0b want=0", hazard_stall); else passed++;
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mwb_reg_write = 1; mwb_rd = 6; mwb_result = 32'hABCD;
        #1;
        total++; if (alu_in_1 !== 32'hABCD) $display("FAIL lu_fwd got=%h want=abcd", alu_in_1); else passed++;
        total++; if (ex_valid !== 1'b1 || alu_op !== 4'h1) $display("FAIL lu_exec got=%0b/%h want=1/1", ex_valid, alu_op); else passed++;
        idle();
        set_id(1, 0, 0, 6, 32'h0, 32'h0, 32'h8, 1, 4'h0, 1, 1);
        tick();
        set_id(1, 2, 6, 0, 32'h0, 32'h0, 32'h4, 1, 4'h0, 0, 0);
        #1;
        total++; if (hazard_stall !== 1'b1) $display("FAIL lu_store got=%0b want=1", hazard_stall); else passed++;
        id_reg_write = 1;
        #1;
        total++; if (hazard_stall !== 1'b0) $display("FAIL lu_imm_rs2 got=%0b want=0", hazard_stall); else passed++;
        idle();
        set_id(1, 0, 0, 0, 32'h0, 32'h0, 32'h8, 1, 4'h0, 1, 1);
        tick();
        set_id(1, 0, 0, 3, 32'h0, 32'h0, 32'h0, 0, 4'h1, 1, 0);
        #1;
        total++; if (hazard_stall !== 1'b0) $display("FAIL lu_x0 got=%0b want=0", hazard_stall); else passed++;
        idle();
    endtask

    task automatic test_flush_stall();
        set_id(1, 1, 2, 9, 32'h1, 32'h2, 32'h0, 0, 4'h3, 1, 0);
        tick();
        total++; if (ex_valid !== 1'b1 || alu_op !== 4'h3) $display("FAIL fs_load got=%0b/%h want=1/3", ex_valid, alu_op); else passed++;
        flush = 1; stall = 1;
        tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL fs_flush_valid got=%0b want=0", ex_valid); else passed++;
        total++; if (alu_op !== 4'hF || ex_reg_write !== 1'b0) $display("FAIL fs_flush_op got=%h/%0b want=f/0", alu_op, ex_reg_write); else passed++;
        flush = 0; stall = 0;
        set_id(1, 1, 2, 10, 32'h10, 32'h20, 32'h0, 0, 4'h5, 1, 0);
        tick();
        stall = 1;
        set_id(1, 3, 4, 12, 32'h30, 32'h40, 32'h0, 1, 4'h7, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (alu_op !== 4'h5) $display("FAIL fs_stall_op[%0d] got=%h want=5", i, alu_op); else passed++;
            total++; if (ex_rd !== 5'd10 || ex_valid !== 1'b1) $display("FAIL fs_stall_rd[%0d] got=%0d/%0b want=10/1", i, ex_rd, ex_valid); else passed++;
            total++; if (alu_in_1 !== 32'h10 || ex_mem_read !== 1'b0) $display("FAIL fs_stall_data[%0d] got=%h/%0b want=10/0", i, alu_in_1, ex_mem_read); else passed++;
        end
        idle();
    endtask

    task automatic test_imm_store();
        set_id(1, 1, 8, 2, 32'h1, 32'h0, 32'hFFFF_FFF0, 1, 4'h0, 1, 0);
        tick();
        exm_reg_write = 1; exm_rd = 8; exm_result = 32'h55;
        #1;
        total++; if (alu_in_2 !== 32'hFFFF_FFF0) $display("FAIL imm_in2 got=%h want=fffffff0", alu_in_2); else passed++;
        total++; if (ex_store_data !== 32'h55) $display("FAIL imm_store got=%h want=55", ex_store_data); else passed++;
        idle();
    endtask

    // Model of what instruction sits in EX; operands resolved by newest-producer lookup
    logic        m_v, m_src, m_rw, m_mr;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_d1, m_d2, m_imm;
    logic [3:0]  m_op;

    function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] latched);
        if (rs == 0) return latched;
        if (exm_reg_write && exm_rd == rs) return exm_result;
        if (mwb_reg_write && mwb_rd == rs) return mwb_result;
        return latched;
    endfunction

    task automatic make_empty();
        m_v = 0; m_src = 0; m_rw = 0; m_mr = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        m_d1 = 0; m_d2 = 0; m_imm = 0; m_op = 4'hF;
    endtask

    task automatic test_random();
        logic exp_h;
        logic [31:0] op2;
        make_empty();
        m_op = 4'h0;
        for (int n = 0; n < 300; n++) begin
            set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            stall = $urandom_range(0, 7) == 0;
            flush = $urandom_range(0, 9) == 0;
            #1;
            exp_h = id_valid && m_v && m_mr && m_rd != 0 &&
                    (id_rs1 == m_rd || (id_rs2 == m_rd && (!id_alu_src || !id_reg_write)));
            total++; if (hazard_stall !== exp_h) $display("FAIL rnd_hazard[%0d] got=%0b want=%0b", n, hazard_stall, exp_h); else passed++;
            if (flush || (!stall && exp_h)) make_empty();
            else if (!stall) begin
                m_v = id_valid; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
                m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm; m_src = id_alu_src;
                m_op = id_alu_op; m_rw = id_reg_write && id_valid; m_mr = id_mem_read && id_valid;
            end
            tick();
            exm_reg_write = 1'($urandom_range(0, 1)); exm_rd = 5'($urandom_range(0, 3)); exm_result = $urandom;
            mwb_reg_write = 1'($urandom_range(0, 1)); mwb_rd = 5'($urandom_range(0, 3)); mwb_result = $urandom;
            #1;
            op2 = operand(m_rs2, m_d2);
            total++; if (alu_in_1 !== operand(m_rs1, m_d1)) $display("FAIL rnd_in1[%0d] got=%h want=%h", n, alu_in_1, operand(m_rs1, m_d1)); else passed++;
            total++; if (alu_in_2 !== (m_src ? m_imm : op2)) $display("FAIL rnd_in2[%0d] got=%h want=%h", n, alu_in_2, m_src ? m_imm : op2); else passed++;
            total++; if (ex_store_data !== op2) $display("FAIL rnd_store[%0d] got=%h want=%h", n, ex_store_data, op2); else passed++;
            total++; if (alu_op !== m_op) $display("FAIL rnd_op[%0d] got=%h want=%h", n, alu_op, m_op); else passed++;
            total++; if ({ex_valid, ex_rd, ex_reg_write, ex_mem_read} !== {m_v, m_rd, m_rw, m_mr})
                $display("FAIL rnd_ctrl[%0d] got=%b want=%b", n, {ex_valid, ex_rd, ex_reg_write, ex_mem_read}, {m_v, m_rd, m_rw, m_mr});
            else passed++;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_reset_midstream();
        test_forward();
        test_priority();
        test_load_use();
        test_flush_stall();
        test_imm_store();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
